// File: rtl/dma_pkg.sv
// Shared types and sizing helpers for the DMA channel arbiter.
// Holds the default channel count and the scheduler state encoding.
package dma_pkg;

    localparam int NCH = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARB,
        S_GRANT,
        S_REL
    } state_t;

    function automatic int cnt_w(input int lim);
        return (lim < 2) ? 1 : $clog2(lim);
    endfunction

endpackage

// File: rtl/dma_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping around, returned as a one-hot vector.
module dma_rr_pick #(
    parameter int NCH = 4,
    parameter int PW  = 2
) (
    input  logic [NCH-1:0] req,
    input  logic [PW-1:0]  ptr,
    output logic [NCH-1:0] gnt,
    output logic           vld
);

    logic hit;

    always_comb begin
        gnt = '0;
        hit = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (!hit && req[(int'(ptr) + i) % NCH]) begin
                gnt[(int'(ptr) + i) % NCH] = 1'b1;
                hit = 1'b1;
            end
        end
    end

    assign vld = |req;

endmodule

// File: rtl/dma_ch_arbiter.sv
// Schedules DMA channels onto the shared datapath with bounded bursts,
// two priority classes, round-robin rotation and a stall watchdog.
module dma_ch_arbiter #(
    parameter int NCH       = dma_pkg::NCH,
    parameter int BURST_LIM = 4,
    parameter int WDOG_W    = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] ch_valid,
    input  logic [NCH-1:0] ch_hi,
    input  logic [NCH-1:0] ch_done,
    input  logic           req_done,
    input  logic [NCH-1:0] irq_clr,
    output logic [NCH-1:0] grant,
    output logic           busy,
    output logic [NCH-1:0] ch_irq,
    output logic [NCH-1:0] ch_err
);

    import dma_pkg::*;

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = cnt_w(BURST_LIM);

    state_t state, state_nxt;

    logic [NCH-1:0]    elig;
    logic [NCH-1:0]    hi_set;
    logic [NCH-1:0]    hi_gnt;
    logic [NCH-1:0]    all_gnt;
    logic              hi_vld;
    logic              all_vld;
    logic [NCH-1:0]    pick;
    logic [PW-1:0]     pick_idx;
    logic [PW-1:0]     gidx;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     ptr_nxt;
    logic [CW-1:0]     burst_cnt;
    logic [WDOG_W-1:0] wdog;
    logic [WDOG_W-1:0] wdog_nxt;
    logic [NCH-1:0]    set_irq;
    logic [NCH-1:0]    set_err;
    logic              burst_end;
    logic              stall;

    assign elig   = ch_valid & ~ch_done;
    assign hi_set = elig & ch_hi;

    dma_rr_pick #(.NCH(NCH), .PW(PW)) u_pick_hi (
        .req (hi_set),
        .ptr (rr_ptr),
        .gnt (hi_gnt),
        .vld (hi_vld)
    );

    dma_rr_pick #(.NCH(NCH), .PW(PW)) u_pick_all (
        .req (elig),
        .ptr (rr_ptr),
        .gnt (all_gnt),
        .vld (all_vld)
    );

    assign pick = hi_vld ? hi_gnt : all_gnt;

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (pick[i]) pick_idx = PW'(i);
        end
    end

    assign ptr_nxt = (gidx == PW'(NCH - 1)) ? '0 : gidx + 1'b1;

    // Watchdog fires on the cycle its count would reach all-ones.
    assign wdog_nxt  = req_done ? '0 : wdog + 1'b1;
    assign stall     = !req_done && (wdog_nxt == '1);
    assign burst_end = req_done && (burst_cnt == CW'(BURST_LIM - 1));

    always_comb begin
        state_nxt = state;
        set_irq   = '0;
        set_err   = '0;
        unique case (state)
            S_IDLE: begin
                if (|elig) state_nxt = S_ARB;
            end
            S_ARB: begin
                state_nxt = all_vld ? S_GRANT : S_IDLE;
            end
            S_GRANT: begin
                if (ch_done[gidx]) begin
                    set_irq[gidx] = 1'b1;
                    state_nxt     = S_REL;
                end else if (!ch_valid[gidx]) begin
                    state_nxt = S_REL;
                end else if (stall) begin
                    set_err[gidx] = 1'b1;
                    state_nxt     = S_REL;
                end else if (burst_end) begin
                    state_nxt = S_REL;
                end
            end
            S_REL: begin
                state_nxt = (|elig) ? S_ARB : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            grant     <= '0;
            gidx      <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            wdog      <= '0;
            ch_irq    <= '0;
            ch_err    <= '0;
        end else begin
            state  <= state_nxt;
            ch_irq <= (ch_irq & ~irq_clr) | set_irq;
            ch_err <= (ch_err & ~irq_clr) | set_err;
            if (state == S_ARB && all_vld) begin
                grant <= pick;
                gidx  <= pick_idx;
            end
            if (state == S_GRANT) begin
                if (state_nxt == S_REL) grant <= '0;
                if (req_done) burst_cnt <= burst_cnt + 1'b1;
                wdog <= wdog_nxt;
            end
            if (state == S_REL) begin
                rr_ptr    <= ptr_nxt;
                burst_cnt <= '0;
                wdog      <= '0;
            end
        end
    end

    assign busy = |grant;

endmodule

// File: tb/tb_dma_ch_arbiter.sv
// Bench for dma_ch_arbiter: directed scenarios plus random traffic,
// all checked against a phase-level reference model of the scheduler.
module tb_dma_ch_arbiter;

    localparam int BL   = 4;
    localparam int WW   = 4;
    localparam int WLIM = (1 << WW) - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] ch_valid = '0;
    logic [3:0] ch_hi = '0;
    logic [3:0] ch_done = '0;
    logic       req_done = 1'b0;
    logic [3:0] irq_clr = '0;
    logic [3:0] grant;
    logic       busy;
    logic [3:0] ch_irq;
    logic [3:0] ch_err;

    int n_chk = 0;
    int n_fail = 0;

    // Model: phase 0 idle, 1 choosing, 2 owning bus, 3 releasing.
    int         m_ph;
    int         m_g;
    int         m_ptr;
    int         m_bursts;
    int         m_quiet;
    logic [3:0] m_irq;
    logic [3:0] m_err;

    always #5 clk = ~clk;

    dma_ch_arbiter #(.NCH(4), .BURST_LIM(BL), .WDOG_W(WW)) dut (
        .clk      (clk),
        .rst      (rst),
        .ch_valid (ch_valid),
        .ch_hi    (ch_hi),
        .ch_done  (ch_done),
        .req_done (req_done),
        .irq_clr  (irq_clr),
        .grant    (grant),
        .busy     (busy),
        .ch_irq   (ch_irq),
        .ch_err   (ch_err)
    );

    task automatic check(input string tag, input logic [3:0] got,
                         input logic [3:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_grant();
        return (m_ph == 2) ? 4'(1 << m_g) : 4'h0;
    endfunction

    task automatic m_reset();
        m_ph = 0; m_g = 0; m_ptr = 0; m_bursts = 0; m_quiet = 0;
        m_irq = '0; m_err = '0;
    endtask

    task automatic m_step();
        logic [3:0] elig;
        logic [3:0] cand;
        bit         found;
        elig  = ch_valid & ~ch_done;
        m_irq = m_irq & ~irq_clr;
        m_err = m_err & ~irq_clr;
        found = 0;
        case (m_ph)
            0: if (elig != 0) m_ph = 1;
            1: begin
                cand = ((elig & ch_hi) != 0) ? (elig & ch_hi) : elig;
                if (cand == 0) m_ph = 0;
                else begin
                    for (int k = 0; k < 4; k++) begin
                        if (!found && cand[(m_ptr + k) % 4]) begin
                            m_g = (m_ptr + k) % 4;
                            found = 1;
                        end
                    end
                    m_ph = 2; m_bursts = 0; m_quiet = 0;
                end
            end
            2: begin
                if (ch_done[m_g]) begin
                    m_irq[m_g] = 1'b1; m_ph = 3;
                end else if (!ch_valid[m_g]) begin
                    m_ph = 3;
                end else if (!req_done && m_quiet + 1 == WLIM) begin
                    m_err[m_g] = 1'b1; m_ph = 3;
                end else if (req_done && m_bursts + 1 == BL) begin
                    m_ph = 3;
                end else if (req_done) begin
                    m_bursts++; m_quiet = 0;
                end else begin
                    m_quiet++;
                end
                if (m_ph == 3) m_ptr = (m_g + 1) % 4;
            end
            default: m_ph = (elig != 0) ? 1 : 0;
        endcase
    endtask

    task automatic check_all();
        check("grant", grant, m_grant());
        check("busy", {3'b0, busy}, {3'b0, m_grant() != 0});
        check("ch_irq", ch_irq, m_irq);
        check("ch_err", ch_err, m_err);
    endtask

    task automatic tick();
        m_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        ch_valid = '0; ch_hi = '0; ch_done = '0;
        req_done = 1'b0; irq_clr = '0;
        rst = 1'b0;
        m_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;
    endtask

    logic [3:0] q[$];
    logic [3:0] prev;
    logic [3:0] t2_exp [5];
    bit         seen;
    int         pct;

    initial begin
        t2_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // 1: latency and burst-limited hold
        do_reset();
        ch_valid = 4'b0001;
        tick();
        check("t1_arb", grant, 4'b0000);
        tick();
        check("t1_lat", grant, 4'b0001);
        req_done = 1'b1;
        repeat (4) tick();
        req_done = 1'b0;
        check("t1_rel", grant, 4'b0000);
        tick();
        tick();
        check("t1_again", grant, 4'b0001);

        // 2: plain round-robin order
        do_reset();
        ch_valid = 4'b1111;
        req_done = 1'b1;
        prev = '0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (grant != 0 && prev == 0) q.push_back(grant);
            prev = grant;
        end
        check("t2_count", 4'(q.size() >= 5), 4'd1);
        for (int i = 0; i < 5 && i < q.size(); i++) check("t2_order", q[i], t2_exp[i]);

        // 3: high class owns the bus until complete
        do_reset();
        ch_valid = 4'b1111;
        ch_hi = 4'b0100;
        req_done = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            check("t3_hi", 4'(grant == 0 || grant == 4'b0100), 4'd1);
        end
        ch_done = 4'b0100;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!seen && grant != 0 && grant != 4'b0100) begin
                seen = 1;
                check("t3_next", grant, 4'b1000);
            end
        end
        check("t3_seen", 4'(seen), 4'd1);

        // 4: completion flag, clear, set-beats-clear
        do_reset();
        ch_valid = 4'b0010;
        tick();
        tick();
        check("t4_grant", grant, 4'b0010);
        req_done = 1'b1;
        repeat (3) tick();
        ch_done = 4'b0010;
        tick();
        req_done = 1'b0;
        check("t4_irq", ch_irq, 4'b0010);
        check("t4_err", ch_err, 4'b0000);
        tick();
        irq_clr = 4'b0010;
        tick();
        irq_clr = '0;
        check("t4_clr", ch_irq, 4'b0000);
        ch_done = '0;
        tick();
        tick();
        ch_done = 4'b0010;
        irq_clr = 4'b0010;
        tick();
        irq_clr = '0;
        check("t4_setwins", ch_irq, 4'b0010);

        // 5: watchdog stall, then rotate past the stalled channel
        do_reset();
        ch_valid = 4'b1000;
        tick();
        tick();
        check("t5_grant", grant, 4'b1000);
        ch_valid = 4'b1001;
        repeat (WLIM - 1) tick();
        check("t5_hold", grant, 4'b1000);
        tick();
        check("t5_drop", grant, 4'b0000);
        check("t5_err", ch_err, 4'b1000);
        tick();
        tick();
        check("t5_rot", grant, 4'b0001);

        // 6: software abort and async reset mid-grant
        do_reset();
        ch_valid = 4'b0001;
        tick();
        tick();
        ch_valid = 4'b0000;
        tick();
        check("t6_abort", grant, 4'b0000);
        ch_valid = 4'b0001;
        tick();
        tick();
        check("t6_regrant", grant, 4'b0001);
        #2;
        rst = 1'b0;
        m_reset();
        #1;
        check("t6_async", grant, 4'b0000);
        check_all();
        rst = 1'b1;

        // random traffic against the model
        do_reset();
        pct = 80;
        for (int n = 0; n < 900; n++) begin
            if (n % 100 == 0) begin
                case ($urandom_range(0, 2))
                    0: pct = 85;
                    1: pct = 30;
                    default: pct = 2;
                endcase
            end
            if (n % 9 == 0) begin
                ch_valid = 4'($urandom);
                ch_hi = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            end
            ch_done = ($urandom_range(0, 11) == 0) ? 4'($urandom) : 4'h0;
            req_done = ($urandom_range(0, 99) < pct);
            irq_clr = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
